uart_tx_serializer: RTL and testbench
=====================================

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning frame payload width in bits (legal values 2..16).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port P_DATA  input  DATA_WIDTH  parallel payload from the upstream producer.
REQ-005 SHALL have port Data_Valid  input  1  payload-valid strobe, normally one cycle wide.
REQ-006 SHALL have port PAR_TYP  input  1  parity type: 0 = even, 1 = odd.
REQ-007 SHALL have port ser_en  input  1  shift enable from the TX controller, high during data-bit cycles.
REQ-008 SHALL have port ser_data  output  1  current serial data bit.
REQ-009 SHALL have port ser_done  output  1  last data bit on ser_data this cycle.
REQ-010 SHALL have port par_bit  output  1  parity bit of the captured payload.

Function
REQ-011 SHALL hold internal state: shift register (DATA_WIDTH), bit counter ($clog2(DATA_WIDTH) bits), active flag, parity register.
REQ-012 SHALL capture the payload when load = Data_Valid & ~ser_en & ~active: shift register <= P_DATA, counter <= 0, active <= 1, parity register <= parity of P_DATA.
REQ-013 SHALL ignore Data_Valid when ser_en=1 or active=1; held registers remain unchanged.
REQ-014 SHALL drive ser_data combinationally from shift register bit 0, LSB first.
REQ-015 SHALL shift the register right by one, zero-filled, and increment the counter on each cycle with ser_en=1 and active=1.
REQ-016 SHALL assert ser_done combinationally when ser_en=1, active=1 and counter = DATA_WIDTH-1.
REQ-017 SHALL clear active and wrap the counter to 0 on the edge that ends the ser_done cycle.
REQ-018 SHALL ignore ser_en when active=0: no shift, no count, ser_done=0.
REQ-019 SHALL compute parity as XOR-reduce(P_DATA) XOR PAR_TYP, sampled at load, and hold it on par_bit until the next load.
REQ-020 SHALL load back-to-back on the cycle after ser_done when Data_Valid is high; the controller's STOP-to-START transition relies on this.
REQ-021 SHALL have the upstream guarantee that Data_Valid is asserted only while the controller is in IDLE or STOP; behaviour under other Data_Valid timing is undefined.
REQ-022 SHALL produce first data bit latency of one clock from load; ser_data is valid from the cycle after load.

Reset
REQ-023 SHALL asynchronously clear the shift register, counter, active flag and parity register to 0 while rst=0, so ser_data=0, ser_done=0 and par_bit=0.
REQ-024 SHALL abandon any frame in progress on reset assertion; the first load after release SHALL behave as from power-up.

Configuration
REQ-025 SHALL have macro UART_TX_PARITY_EN: when defined, parity logic per REQ-019 is present; when undefined, par_bit is constant 0, PAR_TYP is unused and no parity register exists.

Structure
REQ-026 SHALL place the DATA_WIDTH default and the parity-type encodings (EVEN=0, ODD=1) in shared package uart_pkg.
REQ-027 SHALL implement parity as sub-module uart_parity_calc (payload and type in, registered parity out, load enable), instantiated only under UART_TX_PARITY_EN.

Verification
REQ-028 SHALL cover basic frame: DATA_WIDTH=8, P_DATA=0xA5 with one Data_Valid pulse, ser_en high 8 cycles -> ser_data 1,0,1,0,0,1,0,1; ser_done high only on the 8th cycle.
REQ-029 SHALL cover parity: P_DATA=0x07 with PAR_TYP=0 -> par_bit=1; with PAR_TYP=1 -> par_bit=0; with macro undefined -> par_bit=0.
REQ-030 SHALL cover back-to-back frames: 0x3C, then Data_Valid with 0xC3 on the cycle after ser_done -> second frame shifts 1,1,0,0,0,0,1,1 with no dropped bit.
REQ-031 SHALL cover ignored strobe: Data_Valid with 0xFF during the 4th ser_en cycle of 0x00 -> remaining bits stay 0 and par_bit is unchanged.
REQ-032 SHALL cover stray enable: ser_en high 3 cycles with no load -> ser_data=0, ser_done=0, counter stays 0.
REQ-033 SHALL cover mid-frame reset: rst low after 3 bits of 0x55 -> all outputs 0 immediately; a new 0x81 frame after release shifts 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: default payload width and parity-type encodings.
package uart_pkg;

   localparam int DATA_WIDTH_DEF = 8;

   localparam logic PAR_TYP_EVEN = 1'b0;
   localparam logic PAR_TYP_ODD  = 1'b1;

   typedef enum logic {
      PAR_EVEN = PAR_TYP_EVEN,
      PAR_ODD  = PAR_TYP_ODD
   } par_typ_e;

endpackage

// File: rtl/uart_parity_calc.sv
// Registered parity of a UART payload, captured on a load strobe and held until the next load.
module uart_parity_calc
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_load,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_par_typ,
   output logic                  o_par_bit
);

   logic r_par;
   logic w_par_next;

   // Odd parity is the even-parity bit inverted.
   assign w_par_next = (^i_data) ^ (i_par_typ == PAR_TYP_ODD);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_par <= 1'b0;
      end else if (i_load) begin
         r_par <= w_par_next;
      end
   end

   assign o_par_bit = r_par;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART payload serializer: captures a word on Data_Valid and shifts it out LSB first under ser_en.
// Build option: define UART_TX_PARITY_EN to include the parity register; otherwise par_bit is tied to 0.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_TYP,
   input  logic                  ser_en,
   output logic                  ser_data,
   output logic                  ser_done,
   output logic                  par_bit
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] r_shift;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_active;

   logic w_load;
   logic w_shift;
   logic w_last;

   // A new word is accepted only between frames, never while the controller is shifting.
   assign w_load  = Data_Valid & ~ser_en & ~r_active;
   assign w_shift = ser_en & r_active;
   assign w_last  = w_shift & (r_cnt == LAST_CNT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shift  <= '0;
         r_cnt    <= '0;
         r_active <= 1'b0;
      end else if (w_load) begin
         r_shift  <= P_DATA;
         r_cnt    <= '0;
         r_active <= 1'b1;
      end else if (w_shift) begin
         r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
         if (w_last) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign ser_data = r_shift[0];
   assign ser_done = w_last;

`ifdef UART_TX_PARITY_EN
   uart_parity_calc #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_load),
      .i_data    (P_DATA),
      .i_par_typ (PAR_TYP),
      .o_par_bit (par_bit)
   );
`else
   logic w_unused_par_typ;
   assign w_unused_par_typ = PAR_TYP;
   assign par_bit          = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: directed frames plus randomized traffic vs. a bit-queue model.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

   localparam int DW = 8;

   logic          clk;
   logic          rst;
   logic [DW-1:0] P_DATA;
   logic          Data_Valid;
   logic          PAR_TYP;
   logic          ser_en;
   logic          ser_data;
   logic          ser_done;
   logic          par_bit;

   uart_tx_serializer #(.DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_TYP    (PAR_TYP),
      .ser_en     (ser_en),
      .ser_data   (ser_data),
      .ser_done   (ser_done),
      .par_bit    (par_bit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic sd;
      logic done;
      logic par;
   } exp_t;

   exp_t sb[$];
   logic mq[$];      // bits of the current frame still to be sent, LSB first
   logic m_par;
   int   n_pass;
   int   n_total;
   int   n_ser;

   function automatic logic exp_par(input logic [DW-1:0] d, input logic typ);
`ifdef UART_TX_PARITY_EN
      return (^d) ^ typ;
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string name, input logic act, input logic exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
   endtask

   // One clock of stimulus; the model predicts what the DUT shows during this cycle.
   task automatic step(input logic dv, input logic [DW-1:0] d, input logic typ, input logic en);
      exp_t e;
      Data_Valid = dv;
      P_DATA     = d;
      PAR_TYP    = typ;
      ser_en     = en;
      if (en) begin
         e.par = m_par;
         if (mq.size() > 0) begin
            e.sd   = mq.pop_front();
            e.done = (mq.size() == 0);
         end else begin
            e.sd   = 1'b0;
            e.done = 1'b0;
         end
         sb.push_back(e);
      end else if (dv && mq.size() == 0) begin
         for (int i = 0; i < DW; i++) mq.push_back(d[i]);
         m_par = exp_par(d, typ);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic typ);
      step(1'b1, d, typ, 1'b0);
      for (int i = 0; i < DW; i++) step(1'b0, '0, 1'b0, 1'b1);
   endtask

   // Monitor: every enabled cycle is an output beat that must match the oldest prediction.
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b1 && ser_en === 1'b1) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard_underflow: got beat ser_data=%b ser_done=%b expected none", ser_data, ser_done);
         end else begin
            e = sb.pop_front();
            n_ser++;
            chk($sformatf("ser_data[%0d]", n_ser), ser_data, e.sd);
            chk($sformatf("ser_done[%0d]", n_ser), ser_done, e.done);
            chk($sformatf("par_bit[%0d]", n_ser), par_bit, e.par);
         end
      end
   end

   initial begin
      logic [DW-1:0] d;
      logic          typ;
      n_pass = 0; n_total = 0; n_ser = 0; m_par = 1'b0;
      rst = 1'b0; Data_Valid = 1'b0; P_DATA = '0; PAR_TYP = 1'b0; ser_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ser_data", ser_data, 1'b0);
      chk("reset_ser_done", ser_done, 1'b0);
      chk("reset_par_bit", par_bit, 1'b0);
      rst = 1'b1;
      step(1'b0, '0, 1'b0, 1'b0);

      send(8'hA5, 1'b0);                    // basic frame
      step(1'b0, '0, 1'b0, 1'b0);
      send(8'h07, 1'b0);                    // even parity
      send(8'h07, 1'b1);                    // odd parity, back-to-back
      step(1'b0, '0, 1'b0, 1'b0);
      send(8'h3C, 1'b0);
      send(8'hC3, 1'b0);                    // load on the cycle after ser_done

      step(1'b1, 8'h00, 1'b1, 1'b0);        // strobe during 4th bit must be ignored
      for (int k = 0; k < DW; k++) step(k == 3, 8'hFF, 1'b0, 1'b1);

      repeat (3) step(1'b0, '0, 1'b0, 1'b1); // stray enable with no frame
      send(8'h96, 1'b0);

      step(1'b1, 8'h55, 1'b1, 1'b0);        // mid-frame reset
      repeat (3) step(1'b0, '0, 1'b0, 1'b1);
      ser_en = 1'b0;
      rst    = 1'b0;
      #1;
      chk("midreset_ser_data", ser_data, 1'b0);
      chk("midreset_ser_done", ser_done, 1'b0);
      chk("midreset_par_bit", par_bit, 1'b0);
      mq.delete();
      m_par = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      step(1'b0, '0, 1'b0, 1'b0);
      send(8'h81, 1'b0);

      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 2) != 0) begin
            repeat ($urandom_range(0, 3)) step(1'b0, '0, 1'b0, $urandom_range(0, 1) == 1);
         end
         d   = DW'($urandom);
         typ = 1'($urandom);
         step(1'b1, d, typ, 1'b0);
         for (int i = 0; i < DW; i++)
            step($urandom_range(0, 5) == 0, DW'($urandom), 1'($urandom), 1'b1);
      end

      repeat (3) step(1'b0, '0, 1'b0, 1'b0);
      n_total++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d pending beats expected 0", sb.size());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
